// File: rtl/keypad_emu.sv
// keypad_emu: responder side of a 4x4 membrane keypad matrix.
// Key codes queue in a small FIFO; each one is held pressed for HOLD_CYCLES,
// then released for GAP_CYCLES. Active-low column strobes from the scanner are
// answered with registered active-low row returns.
// Optional contact bounce: define KEYPAD_EMU_BOUNCE_EN (needs HOLD_CYCLES and
// GAP_CYCLES > 16); the default build models a clean contact.
module keypad_emu #(
   parameter int HOLD_CYCLES = 1000,
   parameter int GAP_CYCLES  = 500,
   parameter int DEPTH       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       pressed,
   output logic [3:0] key_active,
   output logic       busy
);

   localparam int AW   = $clog2(DEPTH);
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRESS = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [3:0]    mem [DEPTH];
   logic [AW:0]   wptr, rptr;
   logic          full, empty, push, pop;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          contact;
   logic [3:0]    row_nxt;
   logic [3:0]    row_p1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign empty     = (wptr == rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign key_ready = !full;
   assign push      = key_valid && !full;
   assign pop       = (state == S_IDLE) && !empty;
   assign busy      = !empty || (state != S_IDLE);
   assign row       = row_p1;

   // FIFO storage: data only, never reset
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= key_code;
   end

   // FIFO pointers; push and pop in the same cycle both advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Press/release sequencer: IDLE pops, PRESS holds, GAP releases
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pressed    <= 1'b0;
         key_active <= 4'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  key_active <= mem[rptr[AW-1:0]];
                  cnt        <= HOLD_LD;
                  pressed    <= 1'b1;
                  state      <= S_PRESS;
               end
            end
            S_PRESS: begin
               if (cnt == '0) begin
                  pressed <= 1'b0;
                  cnt     <= GAP_LD;
                  state   <= S_GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == '0) state <= S_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int BOUNCE_CYCLES = 16;
   localparam logic [CW-1:0] HOLD_BT = CW'(HOLD_CYCLES - BOUNCE_CYCLES);
   localparam logic [CW-1:0] GAP_BT  = CW'(GAP_CYCLES - BOUNCE_CYCLES);

   logic [7:0] lfsr;
   logic       bounce_win;

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running chatter source
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // Chatter only during the first BOUNCE_CYCLES of each press and release
   always_comb begin
      bounce_win = 1'b0;
      if (state == S_PRESS && cnt >= HOLD_BT) bounce_win = 1'b1;
      if (state == S_GAP   && cnt >= GAP_BT)  bounce_win = 1'b1;
   end

   assign contact = pressed ^ (bounce_win & lfsr[0]);
`else
   assign contact = pressed;
`endif

   // Only the held key's column strobe can pull its row low
   always_comb begin
      row_nxt = 4'b1111;
      if (contact && !col[key_active[1:0]]) row_nxt[key_active[3:2]] = 1'b0;
   end

   // Row return register: one clk behind the column strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) row_p1 <= 4'b1111;
      else        row_p1 <= row_nxt;
   end

endmodule

// File: tb/tb_keypad_emu.sv
// Bench for keypad_emu: directed and random traffic against a timeline model.
module tb_keypad_emu;

   localparam int HOLD  = 8;
   localparam int GAP   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       key_valid = 1'b0;
   logic       key_ready;
   logic [3:0] col = 4'hF;
   logic [3:0] row;
   logic       pressed;
   logic [3:0] key_active;
   logic       busy;

   always #5 clk = ~clk;

   keypad_emu #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .col        (col),
      .row        (row),
      .pressed    (pressed),
      .key_active (key_active),
      .busy       (busy)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference: queue of codes plus the edge at which the current press began
   logic [3:0] mq[$];
   int         e, last_e;
   int         press_start, next_pop;
   logic [3:0] m_key, prev_key, m_row;
   logic       prev_pressed;
   bit         accepted;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, last_e);
      end
   endtask

   function automatic logic m_pressed_at(input int t);
      return (t >= press_start) && (t < press_start + HOLD);
   endfunction

   function automatic logic m_busy();
      return (mq.size() > 0) || (last_e < press_start + HOLD + GAP);
   endfunction

   task automatic model_reset();
      mq.delete();
      press_start  = -100000;
      next_pop     = -100000;
      m_key        = 4'h0;
      prev_key     = 4'h0;
      prev_pressed = 1'b0;
      m_row        = 4'hF;
      e            = 0;
      last_e       = -1;
   endtask

   task automatic model_edge(input bit v, input logic [3:0] c, input logic [3:0] cl);
      bit do_push;
      m_row = 4'hF;
      if (prev_pressed && !cl[prev_key[1:0]]) m_row[prev_key[3:2]] = 1'b0;
      do_push = v && (mq.size() < DEPTH);
      if (mq.size() > 0 && e >= next_pop) begin
         m_key       = mq.pop_front();
         press_start = e;
         next_pop    = e + HOLD + GAP + 1;
      end
      if (do_push) mq.push_back(c);
      accepted     = do_push;
      prev_pressed = m_pressed_at(e);
      prev_key     = m_key;
      last_e       = e;
      e++;
   endtask

   task automatic step(input bit v, input logic [3:0] c, input logic [3:0] cl);
      key_valid = v;
      key_code  = c;
      col       = cl;
      @(posedge clk);
      model_edge(v, c, cl);
      @(negedge clk);
      check("row", row, m_row);
      check("pressed", {3'b0, pressed}, {3'b0, prev_pressed});
      check("key_active", key_active, m_key);
      check("busy", {3'b0, busy}, {3'b0, m_busy()});
      check("key_ready", {3'b0, key_ready}, {3'b0, logic'(mq.size() < DEPTH)});
   endtask

   task automatic push_code(input logic [3:0] c, input logic [3:0] cl);
      bit ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         step(1'b1, c, cl);
         if (accepted) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("push_timeout", 4'h0, 4'h1);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (!m_busy()) begin
            ok = 1'b1;
            break;
         end
         step(1'b0, 4'h0, 4'hF);
      end
      if (!ok) check("drain_timeout", 4'h0, 4'h1);
   endtask

   function automatic logic [3:0] rand_col();
      logic [3:0] one = 4'b0001;
      case ($urandom_range(0, 3))
         0:       return 4'hF;
         1:       return ~(one << $urandom_range(0, 3));
         2:       return 4'($urandom_range(0, 15));
         default: return ~(one << m_key[1:0]);
      endcase
   endfunction

   initial begin
      logic [3:0] walk [4];
      walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011; walk[3] = 4'b0111;
      model_reset();

      // Reset values while rst_n is held low
      @(negedge clk);
      check("rst_row", row, 4'hF);
      check("rst_pressed", {3'b0, pressed}, 4'h0);
      check("rst_key_active", key_active, 4'h0);
      check("rst_busy", {3'b0, busy}, 4'h0);
      check("rst_key_ready", {3'b0, key_ready}, 4'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Key 6 with column 2 strobed continuously
      for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 4'b1011);
      step(1'b1, 4'h6, 4'b1011);
      for (int i = 0; i < 20; i++) step(1'b0, 4'h0, 4'b1011);

      // Key 6 again with a walking column strobe
      push_code(4'h6, 4'b1110);
      for (int i = 0; i < 16; i++) step(1'b0, 4'h0, walk[i % 4]);
      drain();

      // Back-to-back codes fill the FIFO; extra codes wait on key_ready
      push_code(4'h0, 4'hE);
      push_code(4'h5, 4'hD);
      push_code(4'hA, 4'hB);
      push_code(4'hF, 4'h7);
      push_code(4'h1, 4'hD);
      push_code(4'h2, 4'hB);
      for (int i = 0; i < 40; i++) step(1'b0, 4'h0, rand_col());
      drain();

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         step(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), rand_col());
      end
      drain();

      // Asynchronous reset in the middle of a press with codes queued
      push_code(4'h9, 4'b1101);
      push_code(4'h2, 4'b1101);
      push_code(4'h3, 4'b1101);
      step(1'b0, 4'h0, 4'b1101);
      step(1'b0, 4'h0, 4'b1101);
      check("pre_rst_row", row, 4'b1011);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_row", row, 4'hF);
      check("mid_rst_pressed", {3'b0, pressed}, 4'h0);
      check("mid_rst_busy", {3'b0, busy}, 4'h0);
      check("mid_rst_key_ready", {3'b0, key_ready}, 4'h1);
      check("mid_rst_key_active", key_active, 4'h0);
      @(negedge clk);
      key_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 30; i++) step(1'b0, 4'h0, 4'b1101);

      // More random traffic after the reset
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), rand_col());
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
